// File: rtl/rega_pkg.sv
// Shared types and default tick constants for the irrigation zone scheduler.
package rega_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REFILL   = 3'd1,
        ST_IRRIGATE = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    localparam int unsigned DEF_NZONES       = 4;
    localparam int unsigned DEF_IRR_TICKS    = 600;
    localparam int unsigned DEF_SETTLE_TICKS = 5;
    localparam int unsigned DEF_REFILL_MAX   = 900;
    localparam int unsigned DEF_FERT_TICKS   = 60;
    localparam int unsigned DEF_CNT_W        = 16;
    localparam int unsigned GRANT_W          = 3;

endpackage

// File: rtl/rega_zone_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    localparam int unsigned SW = $clog2(N);

    int unsigned w_j;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        w_j   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            w_j = (32'(ptr) + i) % N;
            if (!valid && req[SW'(w_j)]) begin
                valid = 1'b1;
                idx   = IW'(w_j);
            end
        end
    end

endmodule

// File: rtl/rega_zone_scheduler.sv
// Round-robin tank/pump sharing among garden zones with on-demand refill.
// Optional fertiliser dosing is built when REGA_SCHED_FERT_EN is defined.
module rega_zone_scheduler
    import rega_pkg::*;
#(
    parameter int unsigned NZONES       = DEF_NZONES,
    parameter int unsigned IRR_TICKS    = DEF_IRR_TICKS,
    parameter int unsigned SETTLE_TICKS = DEF_SETTLE_TICKS,
    parameter int unsigned REFILL_MAX   = DEF_REFILL_MAX,
    parameter int unsigned FERT_TICKS   = DEF_FERT_TICKS,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [NZONES-1:0]    req,
    input  logic                 Nv1,
    input  logic                 Nv0,
    input  logic                 Adub,
    output logic [NZONES-1:0]    zone_vlv,
    output logic                 Asp,
    output logic                 Ve,
    output logic                 Fert,
    output logic [GRANT_W-1:0]   grant,
    output logic [NZONES-1:0]    done,
    output logic                 fault
);

    state_t               r_state;
    logic [GRANT_W-1:0]   r_ptr;
    logic [GRANT_W-1:0]   r_grant;
    logic [CNT_W-1:0]     r_irr_cnt;
    logic [CNT_W-1:0]     r_aux_cnt;
    logic                 r_resume;
    logic [NZONES-1:0]    r_zone_vlv;
    logic                 r_asp;
    logic                 r_ve;
    logic                 r_fert;
    logic [NZONES-1:0]    r_done;
    logic                 r_fault;

    state_t               w_state_nxt;
    logic [GRANT_W-1:0]   w_ptr_nxt;
    logic [GRANT_W-1:0]   w_grant_nxt;
    logic [CNT_W-1:0]     w_irr_nxt;
    logic [CNT_W-1:0]     w_aux_nxt;
    logic                 w_resume_nxt;
    logic [NZONES-1:0]    w_done_nxt;
    logic                 w_fert_nxt;

    logic                 w_arb_valid;
    logic [GRANT_W-1:0]   w_arb_idx;
    logic                 w_req_gnt;
    logic [GRANT_W-1:0]   w_ptr_inc;
    logic [CNT_W-1:0]     w_aux_inc;
    logic [CNT_W-1:0]     w_irr_dec;

    rr_arbiter #(
        .N  (NZONES),
        .IW (GRANT_W)
    ) u_arb (
        .req   (req),
        .ptr   (r_ptr),
        .valid (w_arb_valid),
        .idx   (w_arb_idx)
    );

    assign w_req_gnt = |(req & (NZONES'(1) << r_grant));
    assign w_ptr_inc = (r_grant == GRANT_W'(NZONES - 1)) ? '0 : r_grant + GRANT_W'(1);
    assign w_aux_inc = (r_aux_cnt == '1) ? r_aux_cnt : r_aux_cnt + CNT_W'(1);
    assign w_irr_dec = (r_irr_cnt == '0) ? '0 : r_irr_cnt - CNT_W'(1);

    // Next-state: sensor contradiction beats everything; in IRRIGATE low tank > abort > expiry.
    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_grant_nxt  = r_grant;
        w_irr_nxt    = r_irr_cnt;
        w_aux_nxt    = r_aux_cnt;
        w_resume_nxt = r_resume;
        w_done_nxt   = '0;
        if (r_state != ST_FAULT && Nv1 && !Nv0) begin
            w_state_nxt = ST_FAULT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!Nv0) begin
                        w_state_nxt = ST_REFILL;
                        w_aux_nxt   = '0;
                    end else if (w_arb_valid) begin
                        w_state_nxt = ST_IRRIGATE;
                        w_grant_nxt = w_arb_idx;
                        w_irr_nxt   = CNT_W'(IRR_TICKS);
                    end
                end
                ST_REFILL: begin
                    if (tick) w_aux_nxt = w_aux_inc;
                    if (Nv1) begin
                        w_state_nxt  = r_resume ? ST_IRRIGATE : ST_IDLE;
                        w_resume_nxt = 1'b0;
                    end else if (tick && r_aux_cnt >= CNT_W'(REFILL_MAX - 1)) begin
                        w_state_nxt = ST_FAULT;
                    end
                end
                ST_IRRIGATE: begin
                    if (tick) w_irr_nxt = w_irr_dec;
                    if (!Nv0) begin
                        w_state_nxt  = ST_REFILL;
                        w_resume_nxt = 1'b1;
                        w_aux_nxt    = '0;
                    end else if (!w_req_gnt) begin
                        w_state_nxt = ST_SETTLE;
                        w_aux_nxt   = '0;
                        w_ptr_nxt   = w_ptr_inc;
                    end else if (r_irr_cnt == '0 || (tick && r_irr_cnt == CNT_W'(1))) begin
                        // A zero count can only be left over from a tick taken on a low-tank exit.
                        w_state_nxt = ST_SETTLE;
                        w_aux_nxt   = '0;
                        w_ptr_nxt   = w_ptr_inc;
                        w_done_nxt  = NZONES'(1) << r_grant;
                    end
                end
                ST_SETTLE: begin
                    if (tick) begin
                        w_aux_nxt = w_aux_inc;
                        if (r_aux_cnt >= CNT_W'(SETTLE_TICKS - 1)) w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef REGA_SCHED_FERT_EN
    logic [CNT_W-1:0] w_elapsed;

    assign w_elapsed  = CNT_W'(IRR_TICKS) - w_irr_nxt;
    assign w_fert_nxt = (w_state_nxt == ST_IRRIGATE) && Adub && (w_elapsed < CNT_W'(FERT_TICKS));
`else
    logic w_unused_fert;

    assign w_unused_fert = ^{Adub, 1'(FERT_TICKS)};
    assign w_fert_nxt    = 1'b0;
`endif

    // State, counters and outputs; outputs are decoded from the next state so they track r_state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_irr_cnt  <= '0;
            r_aux_cnt  <= '0;
            r_resume   <= 1'b0;
            r_zone_vlv <= '0;
            r_asp      <= 1'b0;
            r_ve       <= 1'b0;
            r_fert     <= 1'b0;
            r_done     <= '0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_grant    <= w_grant_nxt;
            r_irr_cnt  <= w_irr_nxt;
            r_aux_cnt  <= w_aux_nxt;
            r_resume   <= w_resume_nxt;
            r_zone_vlv <= (w_state_nxt == ST_IRRIGATE) ? (NZONES'(1) << w_grant_nxt) : '0;
            r_asp      <= (w_state_nxt == ST_IRRIGATE);
            r_ve       <= (w_state_nxt == ST_REFILL);
            r_fert     <= w_fert_nxt;
            r_done     <= w_done_nxt;
            r_fault    <= (w_state_nxt == ST_FAULT);
        end
    end

    assign zone_vlv = r_zone_vlv;
    assign Asp      = r_asp;
    assign Ve       = r_ve;
    assign Fert     = r_fert;
    assign grant    = r_grant;
    assign done     = r_done;
    assign fault    = r_fault;

endmodule

// File: tb/tb_rega_zone_scheduler.sv
// Directed self-checking bench for rega_zone_scheduler (IRR_TICKS=10, SETTLE_TICKS=1, REFILL_MAX=5).
module tb_rega_zone_scheduler;

    localparam int unsigned NZ = 4;
`ifdef REGA_SCHED_FERT_EN
    localparam int FERT_EXP = 2;
`else
    localparam int FERT_EXP = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          tick;
    logic [NZ-1:0] req;
    logic          Nv1;
    logic          Nv0;
    logic          Adub;
    logic [NZ-1:0] zone_vlv;
    logic          Asp;
    logic          Ve;
    logic          Fert;
    logic [2:0]    grant;
    logic [NZ-1:0] done;
    logic          fault;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rega_zone_scheduler #(
        .NZONES       (NZ),
        .IRR_TICKS    (10),
        .SETTLE_TICKS (1),
        .REFILL_MAX   (5),
        .FERT_TICKS   (2),
        .CNT_W        (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .req      (req),
        .Nv1      (Nv1),
        .Nv0      (Nv0),
        .Adub     (Adub),
        .zone_vlv (zone_vlv),
        .Asp      (Asp),
        .Ve       (Ve),
        .Fert     (Fert),
        .grant    (grant),
        .done     (done),
        .fault    (fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_asp(input string tag);
        int guard = 0;
        while (Asp !== 1'b1 && guard < 40) begin
            step();
            guard++;
        end
        check({tag, "_start"}, 32'(Asp), 1);
    endtask

    // Waits for a grant, counts watering cycles (tick held high) and checks the done pulse.
    task automatic count_water(input string tag, input logic [NZ-1:0] zone, input int gidx,
                               input int exp_n, input int exp_fert);
        int n  = 0;
        int nf = 0;
        wait_asp(tag);
        check({tag, "_zone"}, 32'(zone_vlv), 32'(zone));
        check({tag, "_grant"}, 32'(grant), 32'(gidx));
        while (Asp === 1'b1 && n < 100) begin
            n++;
            if (Fert === 1'b1) nf++;
            step();
        end
        check({tag, "_ticks"}, 32'(n), 32'(exp_n));
        check({tag, "_fert"}, 32'(nf), 32'(exp_fert));
        check({tag, "_done"}, 32'(done), 32'(zone));
        step();
        check({tag, "_done_clr"}, 32'(done), 0);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) check("ve_asp_excl", 32'(Ve & Asp), 0);
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1;
        tick  = 1'b0;
        req   = '0;
        Nv1   = 1'b1;
        Nv0   = 1'b1;
        Adub  = 1'b1;
        step();
        check("rst_vlv",   32'(zone_vlv), 0);
        check("rst_asp",   32'(Asp), 0);
        check("rst_ve",    32'(Ve), 0);
        check("rst_fert",  32'(Fert), 0);
        check("rst_done",  32'(done), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_grant", 32'(grant), 0);
        reset = 1'b0;

        // Round-robin over 4'b1011 from ptr 0: 0, 1, 3, 0
        req  = 4'b1011;
        tick = 1'b1;
        count_water("rr0",  4'b0001, 0, 10, FERT_EXP);
        count_water("rr1",  4'b0010, 1, 10, FERT_EXP);
        count_water("rr3",  4'b1000, 3, 10, FERT_EXP);
        count_water("rr0b", 4'b0001, 0, 10, FERT_EXP);
        req = '0;

        // Low tank with a pending request
        tick = 1'b0;
        step();
        step();
        Nv1 = 1'b0;
        Nv0 = 1'b0;
        req = 4'b0001;
        step();
        check("lt_ve",   32'(Ve), 1);
        check("lt_asp",  32'(Asp), 0);
        check("lt_fert", 32'(Fert), 0);
        step();
        check("lt_ve_hold", 32'(Ve), 1);
        Nv1 = 1'b1;
        Nv0 = 1'b1;
        step();
        check("lt_ve_off",   32'(Ve), 0);
        check("lt_vlv_idle", 32'(zone_vlv), 0);
        step();
        check("lt_vlv", 32'(zone_vlv), 32'(4'b0001));
        check("lt_asp_on", 32'(Asp), 1);

        // Refill after 4 ticks of a 10-tick grant, then resume for the remaining 6
        tick = 1'b1;
        repeat (4) step();
        tick = 1'b0;
        Nv1  = 1'b0;
        Nv0  = 1'b0;
        step();
        check("mr_ve",   32'(Ve), 1);
        check("mr_asp",  32'(Asp), 0);
        check("mr_vlv",  32'(zone_vlv), 0);
        check("mr_fert", 32'(Fert), 0);
        check("mr_done", 32'(done), 0);
        step();
        step();
        Nv1 = 1'b1;
        Nv0 = 1'b1;
        step();
        check("mr_resume_asp", 32'(Asp), 1);
        tick = 1'b1;
        count_water("mr_rest", 4'b0001, 0, 6, 0);

        // Abort zone 2; next search starts at zone 3
        req = 4'b0100;
        wait_asp("ab");
        check("ab_grant", 32'(grant), 2);
        step();
        step();
        req = 4'b1001;
        step();
        check("ab_asp",    32'(Asp), 0);
        check("ab_nodone", 32'(done), 0);
        step();
        check("ab_nodone2", 32'(done), 0);
        count_water("ab_next", 4'b1000, 3, 10, FERT_EXP);
        req = '0;

        // Sensor contradiction mid-grant
        step();
        req = 4'b0001;
        wait_asp("cf");
        step();
        Nv1 = 1'b1;
        Nv0 = 1'b0;
        step();
        check("cf_fault", 32'(fault), 1);
        check("cf_asp",   32'(Asp), 0);
        check("cf_vlv",   32'(zone_vlv), 0);
        check("cf_ve",    32'(Ve), 0);
        check("cf_done",  32'(done), 0);
        check("cf_fert",  32'(Fert), 0);
        Nv0 = 1'b1;
        repeat (3) step();
        check("cf_sticky", 32'(fault), 1);
        check("cf_sticky_asp", 32'(Asp), 0);
        req   = '0;
        reset = 1'b1;
        step();
        check("cf_rst_fault", 32'(fault), 0);
        check("cf_rst_grant", 32'(grant), 0);
        check("cf_rst_vlv",   32'(zone_vlv), 0);
        reset = 1'b0;

        // Refill timeout after REFILL_MAX ticks
        Nv1  = 1'b0;
        Nv0  = 1'b0;
        tick = 1'b1;
        step();
        check("to_ve", 32'(Ve), 1);
        repeat (4) step();
        check("to_ve_hold", 32'(Ve), 1);
        check("to_nofault", 32'(fault), 0);
        step();
        check("to_fault", 32'(fault), 1);
        check("to_ve_off", 32'(Ve), 0);
        reset = 1'b1;
        Nv1   = 1'b1;
        Nv0   = 1'b1;
        step();
        check("to_rst_fault", 32'(fault), 0);
        check("to_rst_ve",    32'(Ve), 0);
        reset = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rega_zone_scheduler.md
# rega_zone_scheduler

Shares the single irrigation tank and sprinkler pump among `NZONES` garden zones. Requests are granted round-robin, and each granted zone is irrigated for a fixed number of time ticks. The tank is refilled on demand, suspending and later resuming any irrigation in progress. The block sits above the per-tank fertiliser/mixer/cleaning FSM, whose `Asp` input it drives, and shares the `Nv1`/`Nv0` level sensors with it.

## Interface
- `NZONES`, 4, number of requesting zones (2..8)
- `IRR_TICKS`, 600, ticks of watering per grant (≥1)
- `SETTLE_TICKS`, 5, ticks with all valves closed between grants (≥1)
- `REFILL_MAX`, 900, refill timeout in ticks (≥1)
- `FERT_TICKS`, 60, fertiliser-dosing ticks at the start of each grant (≥1, < `IRR_TICKS`)
- `CNT_W`, 16, counter width; must hold the largest tick parameter
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `tick`  in  1  one-cycle time-base strobe; all counters advance only when it is high
- `req`  in  NZONES  level request per zone; held while watering is wanted
- `Nv1`  in  1  high-level sensor (1 = tank full)
- `Nv0`  in  1  low-level sensor (1 = water above the low mark)
- `Adub`  in  1  fertiliser enable (used only with `REGA_SCHED_FERT_EN`)
- `zone_vlv`  out  NZONES  one-hot zone valve drive
- `Asp`  out  1  sprinkler/pump enable
- `Ve`  out  1  tank fill valve
- `Fert`  out  1  fertiliser dosing pump
- `grant`  out  3  index of the current or last granted zone
- `done`  out  NZONES  one-cycle pulse when a grant completes normally
- `fault`  out  1  sticky fault flag

## Operation
- Moore FSM with states IDLE, REFILL, IRRIGATE, SETTLE, FAULT. All outputs are decoded from registered state, so there are no combinational input-to-output paths.
- **Priority, evaluated every cycle in every state except FAULT:**
  - `Nv1 & !Nv0` (sensor contradiction) -> FAULT.
  - This check overrides every other transition.
- **IDLE**
  - `!Nv0` -> REFILL, even if requests are pending.
  - Otherwise, if any `req` bit is set -> IRRIGATE. Winner is the first set bit searched upward from `ptr`, wrapping. `grant` <= winner. Counter <= `IRR_TICKS`.
- **REFILL**
  - `Ve`=1 and refill counter running.
  - `Nv1` -> IRRIGATE if the `resume` flag is set, else IDLE. `resume` is cleared on exit.
  - Refill counter reaches `REFILL_MAX` ticks -> FAULT.
- **IRRIGATE**
  - `zone_vlv[grant]`=1, `Asp`=1.
  - Counter decrements on each `tick`. On the tick that makes it 0 -> SETTLE, with a `done[grant]` pulse in the same cycle as the transition.
  - `!Nv0` -> REFILL with `resume`=1. The irrigation counter is frozen, not reloaded.
  - `req[grant]`=0 -> SETTLE with no `done` pulse (abort).
- **SETTLE**
  - All valves closed and `Asp`=0.
  - After `SETTLE_TICKS` ticks -> IDLE.
  - `ptr` <= (`grant`+1) mod `NZONES`; updated on entry to SETTLE.
- **FAULT**
  - All drive outputs 0, `fault`=1.
  - Left only by `reset`.
- **Same-cycle conflicts in IRRIGATE**, resolved in this order:
  1. contradiction
  2. low tank
  3. abort
  4. expiry
- **Arithmetic:** counters are unsigned `CNT_W` bits and saturate at 0, never wrapping.

## Timing
- On the first edge with `reset`=1: state IDLE, `ptr`=0, `grant`=0, counters 0, `resume`=0. `zone_vlv`, `Asp`, `Ve`, `Fert`, `done` and `fault` are all 0.
- Reset asserted mid-operation closes every valve in the cycle after that edge.
- Request to valve latency: with `req` visible in IDLE at edge k, `zone_vlv`/`Asp` are high from edge k+1.
- Watering duration: exactly `IRR_TICKS` `tick` strobes are observed while in IRRIGATE, summed across refill interruptions.
- `done`: high for exactly one cycle, and never asserted on an abort or fault.
- `Ve` and `Asp` are never high in the same cycle.
- `tick` is ignored in IDLE and FAULT.
- A `tick` arriving in the cycle of a state change counts for the state being exited.

## Configuration
- **`REGA_SCHED_FERT_EN` defined:**
  - `Fert`=1 during IRRIGATE while the elapsed ticks of the grant are < `FERT_TICKS` and `Adub`=1.
  - `Fert` is forced 0 during REFILL. After a refill resume, dosing continues only if the grant is still inside its first `FERT_TICKS` ticks.
- **`REGA_SCHED_FERT_EN` not defined:**
  - `Fert` is tied to 0 and `Adub` is unused.
  - No elapsed-tick logic is synthesised.

## Structure
- Shared package `rega_pkg` holds:
  - state encoding constants `ST_IDLE`, `ST_REFILL`, `ST_IRRIGATE`, `ST_SETTLE`, `ST_FAULT`;
  - default tick constants.
- Sub-module `rr_arbiter`: combinational round-robin pick. Inputs `req`, `ptr`; outputs `valid` and `idx`. It is instantiated once.
- The FSM, counters and output decode live in the top module.

## Test plan
- **Round-robin:** `req`=4'b1011, `Nv0`=`Nv1`=1, `IRR_TICKS`=3, `SETTLE_TICKS`=1 -> grants in order 0, 1, 3, 0. Each grant gets 3 ticks of `zone_vlv`, followed by a `done` pulse.
- **Low tank on request:** `req`=4'b0001, `Nv0`=0 -> `Ve`=1, `Asp`=0. Raising `Nv1` (with `Nv0`) -> `Ve`=0 and `zone_vlv`=4'b0001 on the next cycle.
- **Refill mid-grant:** `IRR_TICKS`=10; drop `Nv0` after 4 ticks, then restore `Nv1` -> exactly 6 more ticks of watering, then `done[0]`.
- **Abort:** drop `req[2]` during its grant -> SETTLE, no `done`. The next grant searches from zone 3.
- **Faults:**
  - `Nv1`=1, `Nv0`=0 -> `fault`=1, all outputs 0.
  - Refill exceeding `REFILL_MAX`=5 ticks -> `fault`=1.
  - Fault persists until `reset`, which returns the block to IDLE with all outputs 0.
- **Fertiliser (`REGA_SCHED_FERT_EN`):** `Adub`=1, `FERT_TICKS`=2 -> `Fert`=1 for the first 2 ticks of each grant only. Without the macro, `Fert` stays 0 throughout.
